// File: rtl/microc_stack.sv
// Single-cycle micro-controller datapath: 16-entry register file, 8-op ALU, PC sequencer.
// Define MICROC_STACK_RET_EN to compile in the call/return stack; otherwise PC follows s_inc only.
module microc_stack #(
   parameter int DW     = 8,
   parameter int PW     = 10,
   parameter int SDEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   instr,
   output logic [PW-1:0] pc,
   input  logic          s_inc,
   input  logic          s_inm,
   input  logic          we3,
   input  logic [2:0]    op,
   input  logic          s_call,
   input  logic          s_ret,
   output logic          z,
   output logic [5:0]    opcode,
   output logic          stk_full,
   output logic          stk_empty,
   output logic          stk_err
);

   logic [3:0]           ra1, ra2, wa3;
   logic [DW-1:0]        imm, rd1, rd2, wd3;
   logic signed [DW-1:0] alu_y;
   logic [PW-1:0]        tgt, pc_inc, pc_nxt;
   logic [DW-1:0]        rf [16];

   function automatic logic signed [DW-1:0] alu_f(input logic [2:0] sel,
                                                  input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      case (sel)
         3'b000:  return a;
         3'b001:  return ~a;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return a & b;
         3'b101:  return a | b;
         3'b110:  return -a;
         default: return -b;
      endcase
   endfunction

   assign opcode = instr[15:10];
   assign ra1    = instr[11:8];
   assign ra2    = instr[7:4];
   assign wa3    = instr[3:0];
   assign imm    = DW'(instr[11:4]);
   assign tgt    = instr[6 +: PW];
   assign pc_inc = pc + PW'(1);

   // r0 is never written; its storage slot is simply masked on read
   assign rd1   = (ra1 == 4'd0) ? '0 : rf[ra1];
   assign rd2   = (ra2 == 4'd0) ? '0 : rf[ra2];
   assign alu_y = alu_f(op, rd1, rd2);
   assign wd3   = s_inm ? imm : alu_y;

   always_ff @(posedge clk) begin
      if (we3 && (wa3 != 4'd0))
         rf[wa3] <= wd3;
   end

`ifdef MICROC_STACK_RET_EN
   localparam int DPW = $clog2(SDEPTH + 1);
   localparam int SAW = $clog2(SDEPTH);

   logic [DPW-1:0] depth;
   logic [PW-1:0]  stack [SDEPTH];
   logic           push, pop, fault;
   logic [SAW-1:0] top_idx, push_idx;

   assign stk_full  = (depth == DPW'(SDEPTH));
   assign stk_empty = (depth == '0);
   assign top_idx   = SAW'(depth - 1'b1);
   assign push_idx  = SAW'(depth);

   always_ff @(posedge clk) begin
      if (push)
         stack[push_idx] <= pc_inc;
   end
`else
   logic unused_stk;
   assign unused_stk = s_call ^ s_ret ^ (SDEPTH == 0);
   assign stk_full   = 1'b0;
   assign stk_empty  = 1'b1;
   assign stk_err    = 1'b0;
`endif

   // s_ret wins over s_call; a faulting call/ret degrades to a plain increment
   always_comb begin
      pc_nxt = s_inc ? pc_inc : tgt;
`ifdef MICROC_STACK_RET_EN
      push  = 1'b0;
      pop   = 1'b0;
      fault = 1'b0;
      if (s_ret) begin
         if (!stk_empty) begin
            pc_nxt = stack[top_idx];
            pop    = 1'b1;
         end else begin
            pc_nxt = pc_inc;
            fault  = 1'b1;
         end
      end else if (s_call) begin
         if (!stk_full) begin
            pc_nxt = tgt;
            push   = 1'b1;
         end else begin
            pc_nxt = pc_inc;
            fault  = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= '0;
         z  <= 1'b0;
`ifdef MICROC_STACK_RET_EN
         depth   <= '0;
         stk_err <= 1'b0;
`endif
      end else begin
         pc <= pc_nxt;
         if (we3 && !s_inm)
            z <= (alu_y == '0);
`ifdef MICROC_STACK_RET_EN
         if (push)
            depth <= depth + 1'b1;
         else if (pop)
            depth <= depth - 1'b1;
         if (fault)
            stk_err <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_microc_stack.sv
// Directed bench for microc_stack: DW=8 main instance plus a DW=16 instance on the same inputs.
module tb_microc_stack;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instr = '0;
   logic        s_inc = 1'b1, s_inm = 1'b0, we3 = 1'b0, s_call = 1'b0, s_ret = 1'b0;
   logic [2:0]  op = '0;

   logic [9:0]  pc, pc16;
   logic        z, z16;
   logic [5:0]  opcode, opcode16;
   logic        full, empty, err, full16, empty16, err16;

   int checks = 0;
   int errors = 0;

   microc_stack #(.DW(8), .PW(10), .SDEPTH(4)) dut (
      .clk(clk), .reset(reset), .instr(instr), .pc(pc), .s_inc(s_inc), .s_inm(s_inm),
      .we3(we3), .op(op), .s_call(s_call), .s_ret(s_ret), .z(z), .opcode(opcode),
      .stk_full(full), .stk_empty(empty), .stk_err(err));

   microc_stack #(.DW(16), .PW(10), .SDEPTH(4)) dut16 (
      .clk(clk), .reset(reset), .instr(instr), .pc(pc16), .s_inc(s_inc), .s_inm(s_inm),
      .we3(we3), .op(op), .s_call(s_call), .s_ret(s_ret), .z(z16), .opcode(opcode16),
      .stk_full(full16), .stk_empty(empty16), .stk_err(err16));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] f_rr(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
      return {4'h0, a, b, d};
   endfunction

   function automatic logic [15:0] f_tgt(input logic [9:0] t);
      return {t, 6'h00};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_inc = 1'b1; s_inm = 1'b0; we3 = 1'b0; s_call = 1'b0; s_ret = 1'b0; op = 3'b000;
   endtask

   task automatic ld(input logic [7:0] v, input logic [3:0] d);
      idle(); s_inm = 1'b1; we3 = 1'b1; instr = {4'h0, v, d};
      step();
   endtask

   task automatic alu(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
      idle(); op = o; we3 = 1'b1; instr = f_rr(a, b, d);
      step();
   endtask

   task automatic jump(input logic [9:0] t);
      idle(); s_inc = 1'b0; instr = f_tgt(t);
      step();
   endtask

   task automatic call(input logic [9:0] t);
      idle(); s_call = 1'b1; instr = f_tgt(t);
      step();
   endtask

   task automatic ret();
      idle(); s_ret = 1'b1; instr = f_tgt(10'h3C3);
      step();
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      check("rst_pc", pc, 10'h000);
      check("rst_z", z, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      step(); step();
      reset = 1'b0;

      // arithmetic and zero flag
      ld(8'h05, 4'd1);
      ld(8'h05, 4'd2);
      alu(3'b011, 4'd1, 4'd2, 4'd3);
      check("sub_z", z, 1'b1);
      check("sub_z16", z16, 1'b1);
      alu(3'b010, 4'd1, 4'd2, 4'd3);
      check("add_z", z, 1'b0);
      check("add_z16", z16, 1'b0);
      ld(8'h0A, 4'd4);
      alu(3'b011, 4'd3, 4'd4, 4'd5);
      check("r3_is_10", z, 1'b1);
      check("r3_is_10_16", z16, 1'b1);
      idle(); op = 3'b010; instr = f_rr(4'd1, 4'd2, 4'd6);
      step();
      check("z_hold_we0", z, 1'b1);
      ld(8'h33, 4'd6);
      check("z_hold_inm", z, 1'b1);
      alu(3'b010, 4'd1, 4'd2, 4'd6);
      check("add_nz", z, 1'b0);

      ld(8'hFF, 4'd0);
      alu(3'b000, 4'd0, 4'd1, 4'd12);
      check("r0_zero", z, 1'b1);
      alu(3'b000, 4'd1, 4'd0, 4'd12);
      check("pass_a", z, 1'b0);
      ld(8'hFF, 4'd7);
      alu(3'b001, 4'd7, 4'd0, 4'd8);
      check("not_ff", z, 1'b1);
      check("not_ff16", z16, 1'b0);
      alu(3'b000, 4'd1, 4'd0, 4'd12);
      ld(8'h01, 4'd10);
      alu(3'b010, 4'd7, 4'd10, 4'd11);
      check("add_wrap", z, 1'b1);
      check("add_wrap16", z16, 1'b0);
      ld(8'h0A, 4'd9);
      alu(3'b100, 4'd1, 4'd9, 4'd12);
      check("and", z, 1'b1);
      alu(3'b101, 4'd1, 4'd0, 4'd12);
      check("or", z, 1'b0);
      alu(3'b110, 4'd0, 4'd0, 4'd12);
      check("neg_a0", z, 1'b1);
      alu(3'b110, 4'd1, 4'd0, 4'd12);
      check("neg_a5", z, 1'b0);
      alu(3'b111, 4'd1, 4'd0, 4'd12);
      check("neg_b0", z, 1'b1);
      alu(3'b111, 4'd0, 4'd1, 4'd12);
      check("neg_b5", z, 1'b0);

      idle(); instr = 16'hABCD;
      #1;
      check("opcode", opcode, 6'h2A);

      // PC sequencing
      jump(10'h3FF);
      check("jmp_3ff", pc, 10'h3FF);
      idle(); step();
      check("pc_wrap", pc, 10'h000);
      check("pc_wrap16", pc16, 10'h000);
      jump(10'h155);
      check("jmp_155", pc, 10'h155);

`ifdef MICROC_STACK_RET_EN
      jump(10'h010);
      call(10'h020);
      check("call1_pc", pc, 10'h020);
      call(10'h030);
      call(10'h040);
      check("not_full3", full, 1'b0);
      call(10'h050);
      check("call4_pc", pc, 10'h050);
      check("full4", full, 1'b1);
      check("err_before", err, 1'b0);
      call(10'h123);
      check("ovf_pc", pc, 10'h051);
      check("ovf_err", err, 1'b1);
      ret();
      check("ret1", pc, 10'h041);
      check("full_clear", full, 1'b0);
      ret();
      check("ret2", pc, 10'h031);
      ret();
      check("ret3", pc, 10'h021);
      check("not_empty", empty, 1'b0);
      ret();
      check("ret4", pc, 10'h011);
      check("empty4", empty, 1'b1);

      jump(10'h0A9);
      call(10'h200);
      check("call_a9", pc, 10'h200);
      idle(); s_call = 1'b1; s_ret = 1'b1; instr = f_tgt(10'h300);
      step();
      check("callret_pc", pc, 10'h0AA);
      check("callret_empty", empty, 1'b1);
      check("err_sticky", err, 1'b1);
`else
      jump(10'h0A9);
      call(10'h200);
      check("nostk_call", pc, 10'h0AA);
      check("nostk_empty", empty, 1'b1);
      check("nostk_full", full, 1'b0);
      ret();
      check("nostk_ret", pc, 10'h0AB);
      check("nostk_err", err, 1'b0);
`endif

      // asynchronous reset between edges, then reset held across a call
      alu(3'b000, 4'd0, 4'd0, 4'd1);
      check("z_set", z, 1'b1);
      reset = 1'b1;
      #2;
      check("async_pc", pc, 10'h000);
      check("async_z", z, 1'b0);
      check("async_err", err, 1'b0);
      idle(); s_call = 1'b1; instr = f_tgt(10'h2AA);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(); instr = f_tgt(10'h2AA);
      step();
      check("post_rst_pc", pc, 10'h001);
      check("post_rst_empty", empty, 1'b1);

`ifdef MICROC_STACK_RET_EN
      jump(10'h007);
      ret();
      check("udf_pc", pc, 10'h008);
      check("udf_err", err, 1'b1);
      check("udf_empty", empty, 1'b1);
      call(10'h0AA);
      check("call_after", pc, 10'h0AA);
      check("err_held", err, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/microc_stack.md
MICROC_STACK -- requirements
Module: microc_stack

Interface
REQ-001 Parameters SHALL be: DW, default 8, datapath width (8..32); PW, default 10, PC width (4..10); SDEPTH, default 4, return-stack depth (2..16).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr  input  16  instruction word from external program memory, addressed by pc.
REQ-005 pc  output  PW  current program counter.
REQ-006 s_inc  input  1  1: PC+1; 0: PC <= jump target.
REQ-007 s_inm  input  1  1: write immediate; 0: write ALU result.
REQ-008 we3  input  1  register-file write enable.
REQ-009 op  input  3  ALU operation select.
REQ-010 s_call  input  1  push PC+1, jump to target.
REQ-011 s_ret  input  1  pop stack into PC.
REQ-012 z  output  1  registered zero flag.
REQ-013 opcode  output  6  instr[15:10], to external control unit.
REQ-014 stk_full, stk_empty, stk_err  output  1 each  stack full, stack empty, sticky stack fault.

Function
REQ-015 Fields SHALL be: jump target = instr[15:6] truncated to PW LSBs; immediate = instr[11:4] zero-extended to DW; ra1 = instr[11:8]; ra2 = instr[7:4]; wa3 = instr[3:0].
REQ-016 Register file SHALL hold 16 x DW registers, two combinational reads, one synchronous write on the clk edge when we3=1; r0 SHALL always read 0, and writes to r0 SHALL be discarded.
REQ-017 Write data SHALL be the immediate when s_inm=1, else the ALU result.
REQ-018 ALU with A=rd1, B=rd2, modulo 2^DW: 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 -A; 111 -B.
REQ-019 z SHALL update on the clk edge to (ALU result == 0) only when we3=1 and s_inm=0; otherwise z SHALL hold.
REQ-020 PC priority per edge SHALL be: s_ret, then s_call, then s_inc; when s_ret=1, s_call SHALL be ignored.
REQ-021 PC+1 SHALL wrap modulo 2^PW (all-ones -> 0).
REQ-022 s_call with stack not full SHALL push PC+1 (wrapped), increment depth, and load target in the same edge.
REQ-023 s_call with stack full SHALL NOT push and SHALL NOT jump; PC <= PC+1 and stk_err <= 1.
REQ-024 s_ret with stack not empty SHALL load PC with the top entry and decrement depth in the same edge.
REQ-025 s_ret with stack empty SHALL leave depth at 0; PC <= PC+1 and stk_err <= 1.
REQ-026 stk_full SHALL equal (depth == SDEPTH), stk_empty SHALL equal (depth == 0), both combinational from registered depth.
REQ-027 stk_err SHALL remain 1 until reset; register writes and PC sequencing SHALL be unaffected by its value.
REQ-028 Every instruction SHALL complete in one cycle; no stalls, no bubbles.

Reset
REQ-029 reset asserted SHALL immediately force pc=0, z=0, depth=0, stk_err=0, regardless of clk.
REQ-030 Register-file and stack-entry contents SHALL NOT be reset; r0 still reads 0.
REQ-031 reset asserted mid-call/ret SHALL discard the pending push/pop; the first edge after deassertion executes instr at pc=0.

Configuration
REQ-032 Macro MICROC_STACK_RET_EN defined SHALL compile in the return stack per REQ-020..027.
REQ-033 Macro MICROC_STACK_RET_EN undefined SHALL remove the stack storage; s_call, s_ret ignored; stk_full=0, stk_empty=1, stk_err=0; PC follows s_inc only.

Verification
REQ-034 Load r1=5, r2=5 via s_inm=1; then op=011, ra1=1, ra2=2, wa3=3, we3=1 -> r3=0, z=1 after the edge; next op=010 -> r3=10, z=0.
REQ-035 pc=0x3FF (PW=10), s_inc=1 -> pc=0x000 next cycle; s_inc=0, target 0x155 -> pc=0x155.
REQ-036 SDEPTH=4: four s_call from pc 0x010,0x020,0x030,0x040 -> stk_full=1; fifth s_call at pc=0x050 -> pc=0x051, stk_err=1; four s_ret -> pc 0x041,0x031,0x021,0x011, stk_empty=1.
REQ-037 Empty stack, s_ret at pc=0x007 -> pc=0x008, stk_err=1, held through later valid calls until reset.
REQ-038 s_call=1 and s_ret=1 with depth 1 (top 0x0AA) -> pc=0x0AA, depth 0; reset pulsed between clk edges -> pc=0, z=0, stk_err=0 immediately.
REQ-039 we3=1, wa3=0, immediate 0xFF -> r0 still reads 0; DW=16 run of REQ-034 -> same results, immediate zero-extended.
